// File: rtl/core_rst_seq_pkg.sv
// Shared types and helpers for the per-core reset sequencer.
// No logic; state encoding and counter sizing only.
// Imported by the channel and the top.
package core_rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        QUIESCE = 2'd2
    } core_rst_state_e;

    localparam logic [1:0] ST_HOLD_ENC    = 2'd0;
    localparam logic [1:0] ST_RUN_ENC     = 2'd1;
    localparam logic [1:0] ST_QUIESCE_ENC = 2'd2;

    // One counter serves both the hold window and the quiesce timeout.
    function automatic int cnt_width(input int hold_cycles, input int quiesce_timeout);
        int max_v;
        max_v = (hold_cycles > quiesce_timeout) ? hold_cycles : quiesce_timeout;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/core_rst_seq_ch.sv
// One core channel: run-request synchronizer, HOLD/RUN/QUIESCE FSM, shared counter, sticky timeout.
// Latency: request fall to quiesce_req is SYNC_STAGES+1 edges; ack to reset on the same edge.
// Backpressure: quiesce_ack gates reset entry, bounded by QUIESCE_TIMEOUT.
module core_rst_seq_ch
    import core_rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int QUIESCE_TIMEOUT = 256,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       rst_req_n,
    input  logic       quiesce_ack,
    output logic       quiesce_req,
    output logic       core_rst_n,
    output logic       timeout_o,
    output logic [1:0] core_state
);

    localparam int              CNT_W     = cnt_width(HOLD_CYCLES, QUIESCE_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    core_rst_state_e        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   run_req;

    // Synchronizer resets to 0 so a freshly reset channel asks to stay in reset.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rst_req_n};
    end

    assign run_req = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= HOLD;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (run_req) begin
                        state_d   = RUN;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (!run_req) begin
                    state_d = QUIESCE;
                    cnt_d   = '0;
                end
            end
            QUIESCE: begin
                // Late run requests are ignored here; the reset always completes.
                cnt_d = cnt_q + CNT_ONE;
                if (quiesce_ack) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    assign core_rst_n  = (state_q == RUN) || (state_q == QUIESCE);
    assign quiesce_req = (state_q == QUIESCE);
    assign core_state  = state_q;
    assign timeout_o   = timeout_q;

endmodule

// File: rtl/core_rst_seq.sv
// Per-core reset sequencer: quiesces each core's bus port before holding its reset.
// Latency: see core_rst_seq_ch; channels are fully independent.
// Backpressure: per-core quiesce handshake, timeout-bounded.
module core_rst_seq
    import core_rst_seq_pkg::*;
#(
    parameter int N_CORES         = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int QUIESCE_TIMEOUT = 256,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [N_CORES-1:0]   rst_req_n,
    output logic [N_CORES-1:0]   quiesce_req,
    input  logic [N_CORES-1:0]   quiesce_ack,
    output logic [N_CORES-1:0]   core_rst_n,
    output logic [2*N_CORES-1:0] core_state,
    output logic [N_CORES-1:0]   timeout_o
);

    for (genvar i = 0; i < N_CORES; i++) begin : g_ch
        core_rst_seq_ch #(
            .HOLD_CYCLES     (HOLD_CYCLES),
            .QUIESCE_TIMEOUT (QUIESCE_TIMEOUT),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_n       (rst_n),
            .rst_req_n   (rst_req_n[i]),
            .quiesce_ack (quiesce_ack[i]),
            .quiesce_req (quiesce_req[i]),
            .core_rst_n  (core_rst_n[i]),
            .timeout_o   (timeout_o[i]),
            .core_state  (core_state[2*i+1:2*i])
        );
    end

endmodule

// File: tb/tb_core_rst_seq.sv
// Scoreboarded bench for core_rst_seq: expected output changes are queued with their cycle,
// a negedge monitor pops one per observed output change and compares cycle and value.
module tb_core_rst_seq;

    localparam int N = 2;

    logic           clk_i = 1'b0;
    logic           rst_n;
    logic [N-1:0]   rst_req_n;
    logic [N-1:0]   quiesce_req;
    logic [N-1:0]   quiesce_ack;
    logic [N-1:0]   core_rst_n;
    logic [2*N-1:0] core_state;
    logic [N-1:0]   timeout_o;

    core_rst_seq #(
        .N_CORES         (N),
        .HOLD_CYCLES     (16),
        .QUIESCE_TIMEOUT (256),
        .SYNC_STAGES     (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .rst_req_n   (rst_req_n),
        .quiesce_req (quiesce_req),
        .quiesce_ack (quiesce_ack),
        .core_rst_n  (core_rst_n),
        .core_state  (core_state),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] rn;
        logic [1:0] qr;
        logic [1:0] to;
        logic [3:0] st;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } evt_t;

    evt_t  exp_q[$];
    int    cyc    = 0;
    int    n_chk  = 0;
    int    n_pass = 0;
    snap_t prev_s = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic snap_t cur_snap();
        return {core_rst_n, quiesce_req, timeout_o, core_state};
    endfunction

    function automatic snap_t mk(input logic [1:0] rn, input logic [1:0] qr,
                                 input logic [1:0] to, input logic [1:0] st1,
                                 input logic [1:0] st0);
        return {rn, qr, to, st1, st0};
    endfunction

    task automatic push(input int c, input snap_t s);
        evt_t e;
        e.cyc = c;
        e.s   = s;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk_now(input string nm, input snap_t req);
        snap_t s;
        s = cur_snap();
        n_chk++;
        if (s === req) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, s, req);
    endtask

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clk_i) begin
        snap_t s;
        evt_t  e;
        s = cur_snap();
        if (s !== prev_s) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_change cyc=%0d got=%b required=no change from %b",
                         cyc, s, prev_s);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.s === s) n_pass++;
                else $display("FAIL output_event cyc=%0d got=%b required cyc=%0d val=%b",
                              cyc, s, e.cyc, e.s);
            end
        end
        prev_s = s;
    end

    initial begin
        int    p;
        evt_t  e;
        snap_t all0, both_run, q1, hold1, hold1_to;
        all0     = mk(2'b00, 2'b00, 2'b00, 2'd0, 2'd0);
        both_run = mk(2'b11, 2'b00, 2'b00, 2'd1, 2'd1);
        q1       = mk(2'b11, 2'b10, 2'b00, 2'd2, 2'd1);
        hold1    = mk(2'b01, 2'b00, 2'b00, 2'd0, 2'd1);
        hold1_to = mk(2'b01, 2'b00, 2'b10, 2'd0, 2'd1);

        rst_n       = 1'b1;
        rst_req_n   = 2'b11;
        quiesce_ack = 2'b00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_now("reset_state", all0);

        // Boot: both cores leave reset 16 edges after release.
        p = cyc;
        rst_n = 1'b1;
        push(p + 16, both_run);
        at_cyc(p + 20);

        // Graceful reset of core 1, ack 5 cycles into quiesce.
        p = cyc;
        rst_req_n[1] = 1'b0;
        push(p + 3, q1);
        push(p + 9, hold1);
        at_cyc(p + 8);
        quiesce_ack[1] = 1'b1;
        at_cyc(p + 14);
        quiesce_ack[1] = 1'b0;
        at_cyc(p + 30);
        p = cyc;
        rst_req_n[1] = 1'b1;
        push(p + 3, both_run);
        at_cyc(p + 10);

        // Timeout: no ack, quiesce_req held 256 cycles, then sticky flag until next release.
        p = cyc;
        rst_req_n[1] = 1'b0;
        push(p + 3, q1);
        push(p + 259, hold1_to);
        at_cyc(p + 260);
        rst_req_n[1] = 1'b1;
        push(p + 275, both_run);
        at_cyc(p + 280);

        // Ack coincides with the last timeout cycle: ack wins.
        p = cyc;
        rst_req_n[1] = 1'b0;
        push(p + 3, q1);
        push(p + 259, hold1);
        at_cyc(p + 258);
        quiesce_ack[1] = 1'b1;
        at_cyc(p + 260);
        quiesce_ack[1] = 1'b0;
        rst_req_n[1]   = 1'b1;
        push(p + 275, both_run);
        at_cyc(p + 280);

        // Short request pulse: run request returns during quiesce, reset still completes.
        p = cyc;
        rst_req_n[1] = 1'b0;
        push(p + 3, q1);
        push(p + 10, hold1);
        push(p + 26, both_run);
        at_cyc(p + 4);
        rst_req_n[1] = 1'b1;
        at_cyc(p + 9);
        quiesce_ack[1] = 1'b1;
        at_cyc(p + 12);
        quiesce_ack[1] = 1'b0;
        at_cyc(p + 30);

        // Asynchronous reset mid-quiesce, then a fresh boot.
        p = cyc;
        rst_req_n[1] = 1'b0;
        push(p + 3, q1);
        push(p + 5, all0);
        at_cyc(p + 5);
        rst_n = 1'b0;
        #1;
        chk_now("async_reset_immediate", all0);
        at_cyc(p + 8);
        rst_req_n = 2'b11;
        p = cyc;
        rst_n = 1'b1;
        push(p + 16, both_run);
        at_cyc(p + 20);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            $display("FAIL missing_event got=none by cyc=%0d required cyc=%0d val=%b",
                     cyc, e.cyc, e.s);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
